matrix_commutator: RTL and testbench
====================================

Name: matrix_commutator

Overview:
Parametrised four-step current-commutation controller for a matrix converter with N_OUT output phases, each selecting one of three input phases through six unidirectional switches. It generalises the earlier fixed three-phase design with a programmable dwell time, a clearable clamp fault latch, per-phase busy and select-error status, and a programmable interrupt period. It sits between the modulator, which supplies the selection and current-direction signs, and the gate-driver outputs.

Parameters:
N_OUT, 3, number of output phases (1..8)
DWELL, 200, clk cycles each commutation step is held (≥1; 2 µs at 10 ns clk)
INT_HALF, 1000, clk cycles per interrupt half-period
DW_W, 16, width of the dwell counter (must hold DWELL-1)
IW_W, 16, width of the interrupt counter (must hold INT_HALF-1)

Ports:
clk  in  1  system clock, 10 ns
rst_n  in  1  asynchronous active-low reset
ce  in  1  tick enable; when 0, dwell and interrupt counters freeze
sel  in  3*N_OUT  per-phase one-hot input select; bits [3k+2:3k] = phase k, bit i = input i
dir  in  N_OUT  per-phase current sign; 1 = positive
clamp_signal  in  1  clamp/overcurrent fault request, level
fault_clr  in  1  clears the fault latch, only when clamp_signal = 0
s  out  6*N_OUT  switch gates; s[6k+2i] = forward switch, s[6k+2i+1] = reverse switch of input i, phase k
busy  out  N_OUT  phase k is mid-commutation
sel_err  out  N_OUT  phase k sel is not one-hot (registered)
fault  out  1  latched fault
r, g, b  out  8 each  status colour
interrupt  out  1  square wave, period 2*INT_HALF clk cycles

Behaviour:
- Reset (async, rst_n=0): s=0, busy=0, sel_err=0, fault=0, interrupt=0, all counters 0, every channel in OFF.
- Channel states: OFF, ON, C1, C2, C3, C4. Each channel holds a 2-bit cur index and a latched target tgt and direction d.
- OFF: all six switches 0. On a valid one-hot sel with index j, go to ON with cur=j and that input's switch pair = 11 on the next cycle. No four-step sequence is needed because no switch is conducting.
- ON: pair cur = 11, others 0. If sel is valid and index ≠ cur, latch tgt and d=dir, go to C1, assert busy.
- Step outputs, with F/R denoting the conducting and non-conducting switch for d (d=1 gives F=forward; d=0 swaps them):
  - C1: turn off cur.R.
  - C2: turn on tgt.F.
  - C3: turn off cur.F.
  - C4: turn on tgt.R.
- Each step state lasts DWELL ce-qualified cycles. On leaving C4: cur=tgt, state=ON, busy=0. Latency from accepted request to final gate pattern is 3*DWELL+1 cycles. Busy is high for 4*DWELL cycles when ce stays high.
- sel and dir changes during C1..C4 are ignored. The new sel is evaluated in ON on the cycle after completion.
- An invalid sel (zero or multi-hot): sel_err=1 the next cycle, the channel holds its state, and no transition occurs. sel_err=0 once sel is valid.
- Fault latch: fault is set the cycle after clamp_signal=1, from any state. While fault=1, s is forced to 0 (registered), all channels go to OFF, and busy=0. Fault clears the cycle after fault_clr=1 && clamp_signal=0. If clamp_signal and fault_clr are both 1, the fault is held. After clearing, channels restart from OFF.
- Status colour: fault gives r=255, g=0, b=0. Otherwise, if any busy, r=0, g=255, b=255. Otherwise r=0, g=255, b=0.
- Interrupt: the counter increments when ce=1; at INT_HALF-1 it wraps to 0 and interrupt toggles. The interrupt runs independently of fault.
- Switch pairs never both change within a cycle in C1..C4. No cycle ever has both F switches (cur and tgt) off while in ON or any C-state.
- ce=0 mid-step: the current gate pattern holds and the dwell count freezes.

Decomposition:
- Package matrix_commutator_pkg holds:
  - the channel state enum (OFF, ON, C1..C4);
  - the switch-index offsets FWD=0, REV=1;
  - SW_PER_PHASE=6 and IN_PER_PHASE=3;
  - the colour constants COL_MAX=8'd255 and COL_OFF=8'd0.
- One sub-module, commutation_channel, is instantiated N_OUT times. It contains the state machine, dwell counter, cur/tgt/d registers, sel one-hot check and its 6-bit gate output. The top level holds the fault latch, gating, interrupt divider and colour decode.

Test Plan:
- Reset then sel=3'b001 (N_OUT=1, DWELL=4) -> s=6'b000011 one cycle after, busy=0.
- From ON input0, sel=3'b010, dir=1 -> s steps through 000001, 000101, 000100, 001100, each held 4 cycles; busy high for 16 cycles.
- Same request with dir=0 -> s steps through 000010, 001010, 001000, 001100.
- Mid-C2, clamp_signal=1 -> next cycle s=0, fault=1, r=255, busy=0. Then fault_clr=1 with clamp_signal=1 -> fault stays 1. Then clamp_signal=0 with fault_clr=1 -> fault=0, and with sel=3'b100 -> s=6'b110000.
- sel=3'b011 while in ON -> sel_err=1 and s unchanged. Then sel=3'b100 -> sel_err=0 and commutation starts.
- INT_HALF=5, ce=1 -> interrupt toggles every 5 cycles. ce=0 for 3 cycles -> the toggle is delayed by 3 cycles.

Source files
------------

// File: rtl/matrix_commutator_pkg.sv
// Shared types and helpers for the matrix-converter commutation controller.
// The gate decode is kept here so that every channel builds its switch pattern the same way.
package matrix_commutator_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ON,
    ST_C1,
    ST_C2,
    ST_C3,
    ST_C4
  } chan_state_e;

  localparam logic FWD = 1'b0;
  localparam logic REV = 1'b1;
  localparam int SW_PER_PHASE = 6;
  localparam int IN_PER_PHASE = 3;
  localparam logic [7:0] COL_MAX = 8'd255;
  localparam logic [7:0] COL_OFF = 8'd0;

  function automatic logic is_one_hot(input logic [IN_PER_PHASE-1:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [1:0] one_hot_index(input logic [IN_PER_PHASE-1:0] v);
    return v[2] ? 2'd2 : (v[1] ? 2'd1 : 2'd0);
  endfunction

  // F is the switch that carries the present current direction; R blocks it.
  function automatic logic [SW_PER_PHASE-1:0] gate_pattern(input chan_state_e st,
                                                           input logic [1:0] cur,
                                                           input logic [1:0] tgt,
                                                           input logic d);
    logic [SW_PER_PHASE-1:0] one;
    logic [SW_PER_PHASE-1:0] g;
    logic [2:0] cur_f, cur_r, tgt_f, tgt_r;
    one   = SW_PER_PHASE'(1);
    cur_f = {cur, d ? FWD : REV};
    cur_r = {cur, d ? REV : FWD};
    tgt_f = {tgt, d ? FWD : REV};
    tgt_r = {tgt, d ? REV : FWD};
    g     = '0;
    case (st)
      ST_ON:   g = (one << cur_f) | (one << cur_r);
      ST_C1:   g = one << cur_f;
      ST_C2:   g = (one << cur_f) | (one << tgt_f);
      ST_C3:   g = one << tgt_f;
      ST_C4:   g = (one << tgt_f) | (one << tgt_r);
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/matrix_commutator_channel.sv
// One output phase: four-step commutation state machine with dwell timing.
// Gate outputs are registered from the next-state values so they never glitch.
module commutation_channel
  import matrix_commutator_pkg::*;
#(
  parameter int DWELL = 200,
  parameter int DW_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    kill,
  input  logic [IN_PER_PHASE-1:0] sel,
  input  logic                    dir,
  output logic [SW_PER_PHASE-1:0] s,
  output logic                    busy,
  output logic                    sel_err
);

  localparam logic [DW_W-1:0] LAST = DW_W'(DWELL - 1);

  chan_state_e     state, state_n;
  logic [DW_W-1:0] cnt, cnt_n;
  logic [1:0]      cur, cur_n, tgt, tgt_n;
  logic            d, d_n;
  logic            sel_ok;
  logic [1:0]      sel_idx;

  assign sel_ok  = is_one_hot(sel);
  assign sel_idx = one_hot_index(sel);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur;
    tgt_n   = tgt;
    d_n     = d;
    if (kill) begin
      state_n = ST_OFF;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (sel_ok) begin
            state_n = ST_ON;
            cur_n   = sel_idx;
          end
        end
        ST_ON: begin
          if (sel_ok && (sel_idx != cur)) begin
            state_n = ST_C1;
            tgt_n   = sel_idx;
            d_n     = dir;
            cnt_n   = '0;
          end
        end
        default: begin
          // Step states advance only after DWELL enabled ticks.
          if (ce) begin
            if (cnt == LAST) begin
              cnt_n = '0;
              case (state)
                ST_C1:   state_n = ST_C2;
                ST_C2:   state_n = ST_C3;
                ST_C3:   state_n = ST_C4;
                default: begin
                  state_n = ST_ON;
                  cur_n   = tgt;
                end
              endcase
            end else begin
              cnt_n = cnt + DW_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      cnt     <= '0;
      cur     <= '0;
      tgt     <= '0;
      d       <= 1'b0;
      s       <= '0;
      busy    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cur     <= cur_n;
      tgt     <= tgt_n;
      d       <= d_n;
      s       <= gate_pattern(state_n, cur_n, tgt_n, d_n);
      busy    <= (state_n != ST_OFF) && (state_n != ST_ON);
      sel_err <= !sel_ok;
    end
  end

endmodule

// File: rtl/matrix_commutator.sv
// Matrix-converter commutation controller: per-phase channels, clamp fault latch,
// status colour and interrupt divider.
module matrix_commutator
  import matrix_commutator_pkg::*;
#(
  parameter int N_OUT    = 3,
  parameter int DWELL    = 200,
  parameter int INT_HALF = 1000,
  parameter int DW_W     = 16,
  parameter int IW_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ce,
  input  logic [IN_PER_PHASE*N_OUT-1:0]     sel,
  input  logic [N_OUT-1:0]                  dir,
  input  logic                              clamp_signal,
  input  logic                              fault_clr,
  output logic [SW_PER_PHASE*N_OUT-1:0]     s,
  output logic [N_OUT-1:0]                  busy,
  output logic [N_OUT-1:0]                  sel_err,
  output logic                              fault,
  output logic [7:0]                        r,
  output logic [7:0]                        g,
  output logic [7:0]                        b,
  output logic                              interrupt
);

  localparam logic [IW_W-1:0] INT_LAST = IW_W'(INT_HALF - 1);

  logic            fault_n;
  logic [IW_W-1:0] icnt;

  // Channels are killed by the next fault value so gates drop on the same edge fault rises.
  assign fault_n = clamp_signal | (fault & ~fault_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault <= 1'b0;
    else        fault <= fault_n;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_chan
    commutation_channel #(
      .DWELL(DWELL),
      .DW_W (DW_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .ce     (ce),
      .kill   (fault_n),
      .sel    (sel[IN_PER_PHASE*k +: IN_PER_PHASE]),
      .dir    (dir[k]),
      .s      (s[SW_PER_PHASE*k +: SW_PER_PHASE]),
      .busy   (busy[k]),
      .sel_err(sel_err[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt      <= '0;
      interrupt <= 1'b0;
    end else if (ce) begin
      if (icnt == INT_LAST) begin
        icnt      <= '0;
        interrupt <= ~interrupt;
      end else begin
        icnt <= icnt + IW_W'(1);
      end
    end
  end

  always_comb begin
    r = COL_OFF;
    g = COL_MAX;
    b = COL_OFF;
    if (fault) begin
      r = COL_MAX;
      g = COL_OFF;
    end else if (|busy) begin
      b = COL_MAX;
    end
  end

endmodule

// File: tb/tb_matrix_commutator.sv
// Directed bench for matrix_commutator with one phase, DWELL=4 and INT_HALF=5.
// Expected values are hand-derived gate patterns held in a vector table.
module tb_matrix_commutator;

  localparam int N_OUT    = 1;
  localparam int DWELL    = 4;
  localparam int INT_HALF = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic [2:0] sel;
  logic [0:0] dir;
  logic       clamp_signal;
  logic       fault_clr;
  logic [5:0] s;
  logic [0:0] busy;
  logic [0:0] sel_err;
  logic       fault;
  logic [7:0] r, g, b;
  logic       interrupt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [2:0] sel;
    logic       dir;
    logic       ce;
    logic       clamp;
    logic       clr;
    logic [5:0] exp_s;
    logic       exp_busy;
    logic       exp_err;
    logic       exp_fault;
  } vec_t;

  vec_t vecs[$];

  matrix_commutator #(
    .N_OUT   (N_OUT),
    .DWELL   (DWELL),
    .INT_HALF(INT_HALF),
    .DW_W    (8),
    .IW_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .sel         (sel),
    .dir         (dir),
    .clamp_signal(clamp_signal),
    .fault_clr   (fault_clr),
    .s           (s),
    .busy        (busy),
    .sel_err     (sel_err),
    .fault       (fault),
    .r           (r),
    .g           (g),
    .b           (b),
    .interrupt   (interrupt)
  );

  always #5 clk = ~clk;

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic addN(input int n, input logic [2:0] sl, input logic dr, input logic c,
                      input logic cl, input logic fc, input logic [5:0] es,
                      input logic eb, input logic ee, input logic ef);
    vec_t v;
    v.sel = sl; v.dir = dr; v.ce = c; v.clamp = cl; v.clr = fc;
    v.exp_s = es; v.exp_busy = eb; v.exp_err = ee; v.exp_fault = ef;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    sel          = v.sel;
    dir          = v.dir;
    ce           = v.ce;
    clamp_signal = v.clamp;
    fault_clr    = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [7:0] er, eg, eb;
    if (v.exp_fault)     begin er = 8'd255; eg = 8'd0;   eb = 8'd0;   end
    else if (v.exp_busy) begin er = 8'd0;   eg = 8'd255; eb = 8'd255; end
    else                 begin er = 8'd0;   eg = 8'd255; eb = 8'd0;   end
    compare($sformatf("vec%0d.s", idx),       32'(s),       32'(v.exp_s));
    compare($sformatf("vec%0d.busy", idx),    32'(busy),    32'(v.exp_busy));
    compare($sformatf("vec%0d.sel_err", idx), 32'(sel_err), 32'(v.exp_err));
    compare($sformatf("vec%0d.fault", idx),   32'(fault),   32'(v.exp_fault));
    compare($sformatf("vec%0d.rgb", idx),     32'({r, g, b}), 32'({er, eg, eb}));
  endtask

  task automatic checkReset(input string tag);
    compare({tag, ".s"},         32'(s),         32'h0);
    compare({tag, ".busy"},      32'(busy),      32'h0);
    compare({tag, ".sel_err"},   32'(sel_err),   32'h0);
    compare({tag, ".fault"},     32'(fault),     32'h0);
    compare({tag, ".interrupt"}, 32'(interrupt), 32'h0);
    compare({tag, ".rgb"},       32'({r, g, b}), 32'h00ff00);
  endtask

  initial begin
    logic [1:18] exp_int;
    logic [1:18] ce_pat;
    exp_int = 18'b0000_11111_00000000_1;
    ce_pat  = 18'b111111111111_000_111;

    rst_n = 1'b0; ce = 1'b0; sel = 3'b000; dir = 1'b0;
    clamp_signal = 1'b0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset1");
    rst_n = 1'b1;

    // Interrupt divider, with a three-cycle ce pause stretching the second period.
    for (int k = 1; k <= 18; k++) begin
      ce = ce_pat[k];
      @(posedge clk);
      #1;
      compare($sformatf("int.edge%0d", k), 32'(interrupt), 32'(exp_int[k]));
    end

    rst_n = 1'b0;
    #2;
    checkReset("reset2");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //   n  sel     dir  ce    clamp clr   s          busy  err   fault
    addN(2, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000011, 1'b0, 1'b0, 1'b0);
    addN(1, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000001, 1'b1, 1'b0, 1'b0);
    addN(3, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000001, 1'b1, 1'b0, 1'b0);
    addN(4, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000101, 1'b1, 1'b0, 1'b0);
    addN(4, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000100, 1'b1, 1'b0, 1'b0);
    addN(4, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001100, 1'b1, 1'b0, 1'b0);
    addN(2, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001100, 1'b0, 1'b0, 1'b0);
    addN(4, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001000, 1'b1, 1'b0, 1'b0);
    addN(2, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001010, 1'b1, 1'b0, 1'b0);
    addN(2, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 6'b001010, 1'b1, 1'b0, 1'b0);
    addN(2, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001010, 1'b1, 1'b0, 1'b0);
    addN(4, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000010, 1'b1, 1'b0, 1'b0);
    addN(4, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000011, 1'b1, 1'b0, 1'b0);
    addN(1, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000011, 1'b0, 1'b0, 1'b0);
    addN(4, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000010, 1'b1, 1'b0, 1'b0);
    addN(4, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001010, 1'b1, 1'b0, 1'b0);
    addN(4, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001000, 1'b1, 1'b0, 1'b0);
    addN(4, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001100, 1'b1, 1'b0, 1'b0);
    addN(1, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001100, 1'b0, 1'b0, 1'b0);
    addN(1, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001100, 1'b0, 1'b1, 1'b0);
    addN(1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 6'b001100, 1'b0, 1'b1, 1'b0);
    addN(4, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000100, 1'b1, 1'b0, 1'b0);
    addN(1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 6'b010100, 1'b1, 1'b0, 1'b0);
    addN(2, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1);
    addN(1, 3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b1);
    addN(1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 6'b110000, 1'b0, 1'b0, 1'b0);
    addN(1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 6'b110000, 1'b0, 1'b0, 1'b0);
    addN(1, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 6'b010000, 1'b1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
